load_unit: RTL and testbench

//  Executes RISC-V loads (LB/LH/LW/LBU/LHU) for kakacpu. Consumes the load_kind_t produced by decode_load

---
 rtl/load_unit_pkg.sv | 48 ++++
 rtl/load_unit_extract.sv | 28 ++
 rtl/load_unit.sv | 142 ++++++++++++++
 tb/tb_load_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared types for the kakacpu load path: decoded load kinds, load fault codes and
// the load-unit FSM encoding, plus small decode helpers used by the unit.
package load_unit_pkg;

  typedef enum logic [2:0] {
    lk_lb      = 3'd0,
    lk_lh      = 3'd1,
    lk_lw      = 3'd2,
    lk_lbu     = 3'd3,
    lk_lhu     = 3'd4,
    lk_invalid = 3'd7
  } load_kind_t;

  typedef enum logic [1:0] {
    lf_none       = 2'd0,
    lf_misaligned = 2'd1,
    lf_invalid    = 2'd2,
    lf_bus        = 2'd3
  } load_fault_t;

  typedef logic [1:0] ls_state_t;

  localparam ls_state_t ls_idle = 2'd0;
  localparam ls_state_t ls_req  = 2'd1;
  localparam ls_state_t ls_wait = 2'd2;
  localparam ls_state_t ls_done = 2'd3;

  // Encodings 5 and 6 are unused by decode_load and are treated like lk_invalid.
  function automatic logic kind_is_valid(input load_kind_t kind);
    logic ok;
    case (kind)
      lk_lb, lk_lh, lk_lw, lk_lbu, lk_lhu: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_misaligned(input load_kind_t kind, input logic [1:0] addr_lo);
    logic mis;
    case (kind)
      lk_lh, lk_lhu: mis = addr_lo[0];
      lk_lw:         mis = |addr_lo;
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_unit_extract.sv
// Lane select and sign/zero extension of a little-endian memory word for one load.
// Purely combinational so it can be exercised on its own.
module load_extract
  import load_unit_pkg::*;
(
  input  load_kind_t  kind_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = word_i[8*addr_lo_i +: 8];
    half_w = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (kind_i)
      lk_lb:   data_o = {{24{byte_w[7]}}, byte_w};
      lk_lh:   data_o = {{16{half_w[15]}}, half_w};
      lk_lw:   data_o = word_i;
      lk_lbu:  data_o = {24'd0, byte_w};
      lk_lhu:  data_o = {16'd0, half_w};
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load unit: accepts one load from execute, issues a single word read, and returns the
// extended result (or a fault) to writeback. One load in flight at a time.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  load_kind_t  req_kind,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output load_fault_t wb_fault,
  output ls_state_t   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holding valid keeps its payload stable until that edge, and never waits
  // on ready before raising valid.

  localparam int            CW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  ls_state_t   state_q,    state_d;
  load_kind_t  kind_q,     kind_d;
  logic [1:0]  addr_lo_q,  addr_lo_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [4:0]  rd_q,       rd_d;
  logic [31:0] data_q,     data_d;
  load_fault_t fault_q,    fault_d;
  logic [CW-1:0] cnt_q,    cnt_d;

  logic [31:0] ext_data;

  load_extract u_extract (
    .kind_i    (kind_q),
    .addr_lo_i (addr_lo_q),
    .word_i    (mem_rsp_data),
    .data_o    (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    addr_lo_d  = addr_lo_q;
    mem_addr_d = mem_addr_q;
    rd_d       = rd_q;
    data_d     = data_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    case (state_q)
      ls_idle: begin
        if (req_valid) begin
          kind_d     = req_kind;
          addr_lo_d  = req_addr[1:0];
          mem_addr_d = {req_addr[31:2], 2'b00};
          rd_d       = req_rd;
          data_d     = 32'd0;
          // Invalid and misaligned loads are reported without touching memory.
          if (!kind_is_valid(req_kind)) begin
            fault_d = lf_invalid;
            state_d = ls_done;
          end else if (is_misaligned(req_kind, req_addr[1:0])) begin
            fault_d = lf_misaligned;
            state_d = ls_done;
          end else begin
            fault_d = lf_none;
            state_d = ls_req;
          end
        end
      end
      ls_req: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = ls_wait;
        end
      end
      ls_wait: begin
        // A response arriving on the final timeout cycle still counts.
        if (mem_rsp_valid) begin
          data_d  = ext_data;
          fault_d = lf_none;
          state_d = ls_done;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = 32'd0;
          fault_d = lf_bus;
          state_d = ls_done;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (wb_ready) begin
          state_d = ls_idle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ls_idle;
      kind_q     <= lk_lb;
      addr_lo_q  <= 2'd0;
      mem_addr_q <= 32'd0;
      rd_q       <= 5'd0;
      data_q     <= 32'd0;
      fault_q    <= lf_none;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      addr_lo_q  <= addr_lo_d;
      mem_addr_q <= mem_addr_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_ready     = (state_q == ls_idle);
  assign mem_req_valid = (state_q == ls_req);
  assign mem_addr      = mem_addr_q;
  assign wb_valid      = (state_q == ls_done);
  assign wb_rd         = rd_q;
  assign wb_data       = data_q;
  assign wb_fault      = fault_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: normal loads, fault paths, stalls, timeout and reset abort.
module tb_load_unit;
  import load_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  load_kind_t  req_kind;
  logic [31:0] req_addr;
  logic [4:0]  req_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  load_fault_t wb_fault;
  ls_state_t   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  load_unit #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_kind      (req_kind),
    .req_addr      (req_addr),
    .req_rd        (req_rd),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_fault      (wb_fault),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":req_ready"},     32'(req_ready),     32'd1);
    check({tag, ":mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, ":mem_addr"},      mem_addr,           32'd0);
    check({tag, ":wb_valid"},      32'(wb_valid),      32'd0);
    check({tag, ":wb_rd"},         32'(wb_rd),         32'd0);
    check({tag, ":wb_data"},       wb_data,            32'd0);
    check({tag, ":wb_fault"},      32'(wb_fault),      32'(lf_none));
    check({tag, ":state"},         32'(dbg_state),     32'(ls_idle));
  endtask

  // Driver + memory/writeback responder for one load. Called at a negedge with the unit idle.
  // rsp_delay < 0 means memory never answers; noise drives a bogus response while REQ stalls.
  task automatic run_load(input string tag, input load_kind_t kind, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rsp, input int req_stall,
                          input int rsp_delay, input int wb_stall, input bit noise,
                          input logic [31:0] exp_data, input load_fault_t exp_fault,
                          input int exp_lat);
    int cyc, stall_n, wb_n, rsp_at, wb_lat;
    bit mem_seen, done;
    logic [31:0] exp_w;
    exp_q.push_back(exp_data);
    check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_kind  = kind;
    req_addr  = addr;
    req_rd    = rd;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    cyc = 1; stall_n = 0; wb_n = 0; rsp_at = -1; wb_lat = -1; mem_seen = 1'b0; done = 1'b0;
    exp_w = 32'd0;
    while (!done && cyc < 40) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h5A5A_5A5A;
      wb_ready      = 1'b0;
      if (mem_req_valid) begin
        mem_seen = 1'b1;
        check({tag, ":mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        if (stall_n < req_stall) begin
          stall_n++;
          check({tag, ":req_ready_busy"}, 32'(req_ready), 32'd0);
          if (noise) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hDEAD_BEEF;
          end
        end else begin
          mem_req_ready = 1'b1;
          if (rsp_delay >= 0) rsp_at = cyc + 1 + rsp_delay;
        end
      end
      if (cyc == rsp_at) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rsp;
      end
      if (wb_valid) begin
        if (wb_lat < 0) begin
          wb_lat = cyc;
          exp_w  = exp_q.pop_front();
          check({tag, ":latency"}, 32'(wb_lat), 32'(exp_lat));
        end
        check({tag, ":wb_rd"},    32'(wb_rd),    32'(rd));
        check({tag, ":wb_data"},  wb_data,       exp_w);
        check({tag, ":wb_fault"}, 32'(wb_fault), 32'(exp_fault));
        if (wb_n < wb_stall) begin
          wb_n++;
          check({tag, ":req_ready_done"}, 32'(req_ready), 32'd0);
        end else begin
          wb_ready = 1'b1;
          done     = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    wb_ready      = 1'b0;
    if (!done) check({tag, ":completed"}, 32'd0, 32'd1);
    check({tag, ":mem_issued"}, 32'(mem_seen),
          32'((exp_fault == lf_none || exp_fault == lf_bus) ? 1 : 0));
    check({tag, ":back_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_kind = lk_lb; req_addr = 32'd0; req_rd = 5'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; wb_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // tag, kind, addr, rd, rsp, req_stall, rsp_delay, wb_stall, noise, exp_data, exp_fault, lat
    run_load("lb_1003",  lk_lb,  32'h0000_1003, 5'd5,  32'h8012_3456, 0, 0, 0, 0, 32'hFFFF_FF80, lf_none, 3);
    run_load("lhu_2002", lk_lhu, 32'h0000_2002, 5'd6,  32'hBEEF_1234, 0, 0, 0, 0, 32'h0000_BEEF, lf_none, 3);
    run_load("lh_2002",  lk_lh,  32'h0000_2002, 5'd7,  32'hBEEF_1234, 0, 0, 0, 0, 32'hFFFF_BEEF, lf_none, 3);
    run_load("lw_2000",  lk_lw,  32'h0000_2000, 5'd8,  32'hBEEF_1234, 0, 0, 0, 0, 32'hBEEF_1234, lf_none, 3);
    run_load("lbu_2001", lk_lbu, 32'h0000_2001, 5'd9,  32'hBEEF_1234, 0, 0, 0, 0, 32'h0000_0012, lf_none, 3);
    run_load("lh_2000",  lk_lh,  32'h0000_2000, 5'd10, 32'hBEEF_8234, 0, 0, 0, 0, 32'hFFFF_8234, lf_none, 3);
    run_load("lw_mis",   lk_lw,  32'h0000_2001, 5'd11, 32'h1111_1111, 0, 0, 0, 0, 32'd0, lf_misaligned, 1);
    run_load("lh_mis",   lk_lh,  32'h0000_2003, 5'd12, 32'h1111_1111, 0, 0, 0, 0, 32'd0, lf_misaligned, 1);
    run_load("invalid",  lk_invalid, 32'h0000_2000, 5'd13, 32'h1111_1111, 0, 0, 0, 0, 32'd0, lf_invalid, 1);
    run_load("stall",    lk_lw,  32'h0000_3004, 5'd14, 32'hCAFE_F00D, 3, 0, 2, 1, 32'hCAFE_F00D, lf_none, 6);
    run_load("timeout",  lk_lw,  32'h0000_3008, 5'd15, 32'h0000_0000, 0, -1, 0, 0, 32'd0, lf_bus, 6);
    run_load("rsp_last", lk_lbu, 32'h0000_300A, 5'd16, 32'h00A5_0000, 0, 3, 0, 0, 32'h0000_00A5, lf_none, 6);

    // Reset while waiting for memory: outputs return to reset values immediately.
    req_valid = 1'b1; req_kind = lk_lw; req_addr = 32'h0000_4000; req_rd = 5'd20;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort:in_req", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("abort:in_wait", 32'(dbg_state), 32'(ls_wait));
    #2 rst = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("late_rsp:wb_valid",  32'(wb_valid),  32'd0);
      check("late_rsp:req_ready", 32'(req_ready), 32'd1);
    end
    mem_rsp_valid = 1'b0;
    run_load("lbu_after", lk_lbu, 32'h0000_1003, 5'd21, 32'h8012_3456, 0, 0, 0, 0, 32'h0000_0080, lf_none, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
